// File: rtl/duty_recorder_if.sv
// Bundle of control, capture and playback signals for duty_recorder.
// The master side (duty-cycle generators / controller) drives the requests
// and the captured words; the slave side (the recorder) returns the replayed
// words and status.
interface duty_recorder_if #(
  parameter int DW = 6,
  parameter int CH = 2,
  parameter int AW = 8,
  parameter int PW = 16
);
  logic               rec_en;
  logic               play_en;
  logic               loop_en;
  logic               clear;
  logic               sample_stb;
  logic [CH*DW-1:0]   duty_in;
  logic [PW-1:0]      play_div;
  logic [CH*DW-1:0]   duty_out;
  logic               out_valid;
  logic               done;
  logic               full;
  logic [AW:0]        rec_len;
  logic [1:0]         state;

  modport master (
    output rec_en, play_en, loop_en, clear, sample_stb, duty_in, play_div,
    input  duty_out, out_valid, done, full, rec_len, state
  );

  modport slave (
    input  rec_en, play_en, loop_en, clear, sample_stb, duty_in, play_div,
    output duty_out, out_valid, done, full, rec_len, state
  );
endinterface

// File: rtl/duty_recorder.sv
// Multi-channel record/playback buffer for PWM duty-cycle words.
// Records CH packed duty words per strobe into a DEPTH-entry RAM, replays
// them at a programmable step period (once or looped) and can sweep the
// whole RAM to zero. Pointer arithmetic is bounded by the recorded length,
// not by the RAM size, so short recordings loop on themselves.
module duty_recorder #(
  parameter int DW    = 6,
  parameter int CH    = 2,
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int PW    = 16
) (
  input logic            sysclk,
  input logic            reset,
  duty_recorder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REC   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_L     = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW:0]      rec_len_q, rec_len_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic [PW-1:0]    div_q, div_d;
  logic [CH*DW-1:0] duty_out_q;
  logic             out_valid_q;
  logic             done_q;

  logic [CH*DW-1:0] mem [DEPTH];

  logic full_w;
  logic terminal_w;
  logic last_w;
  logic wr_rec_w;
  logic rd_en_w;
  logic clr_last_w;

  assign full_w     = (rec_len_q == DEPTH_L);
  // Live compare so a shorter period written mid-play takes effect at once.
  assign terminal_w = (div_q >= bus.play_div);
  assign last_w     = ({1'b0, ptr_q} == (rec_len_q - ONE_L));
  assign wr_rec_w   = (state_q == ST_REC) && bus.rec_en && bus.sample_stb &&
                      !full_w && !bus.clear;
  assign rd_en_w    = (state_q == ST_PLAY) && bus.play_en && !bus.clear &&
                      terminal_w;
  assign clr_last_w = (state_q == ST_CLEAR) && (clr_addr_q == LAST_ADDR);

  // Next-state logic for the mode FSM, record length, read pointer,
  // playback divider and clear-sweep address.
  always_comb begin
    state_d    = state_q;
    rec_len_d  = rec_len_q;
    ptr_d      = ptr_q;
    div_d      = div_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (bus.rec_en) begin
          state_d   = ST_REC;
          rec_len_d = '0;
        end else if (bus.play_en && (rec_len_q != '0)) begin
          state_d = ST_PLAY;
          ptr_d   = '0;
          div_d   = '0;
        end
      end
      ST_REC: begin
        if (bus.clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (!bus.rec_en) begin
          state_d = ST_IDLE;
        end else if (wr_rec_w) begin
          rec_len_d = rec_len_q + ONE_L;
        end
      end
      ST_PLAY: begin
        if (bus.clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (!bus.play_en) begin
          state_d = ST_IDLE;
        end else if (terminal_w) begin
          div_d = '0;
          if (last_w) begin
            if (bus.loop_en) begin
              ptr_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end else begin
          div_d = div_q + PW'(1);
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_last_w) begin
          state_d   = ST_IDLE;
          rec_len_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset returns everything to an empty idle recorder.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rec_len_q  <= '0;
      ptr_q      <= '0;
      div_q      <= '0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rec_len_q  <= rec_len_d;
      ptr_q      <= ptr_d;
      div_q      <= div_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Sample RAM write port: recording strobes or the zeroing sweep; not reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      if (wr_rec_w) begin
        mem[rec_len_q[AW-1:0]] <= bus.duty_in;
      end else if (state_q == ST_CLEAR) begin
        mem[clr_addr_q] <= '0;
      end
    end
  end

  // Synchronous RAM read straight into the output register, plus the
  // one-cycle valid/done pulses that accompany each replayed sample.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      duty_out_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= rd_en_w;
      done_q      <= rd_en_w && last_w && !bus.loop_en;
      if (rd_en_w) begin
        duty_out_q <= mem[ptr_q];
      end else if (clr_last_w) begin
        duty_out_q <= '0;
      end
    end
  end

  assign bus.duty_out  = duty_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.full      = full_w;
  assign bus.rec_len   = rec_len_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_duty_recorder.sv
// Directed bench for duty_recorder: a per-cycle vector table covers record,
// one-shot and looped replay, abort and request priority; hand-written
// sequences cover the full buffer, the clear sweep and reset during play.
module tb_duty_recorder;

  logic clk;
  logic reset;

  duty_recorder_if #(.DW(6), .CH(2), .AW(8), .PW(16)) bus ();

  duty_recorder #(.DW(6), .CH(2), .DEPTH(256), .AW(8), .PW(16)) dut (
    .sysclk (clk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic        rec;
    logic        play;
    logic        loop;
    logic        clr;
    logic        stb;
    logic [11:0] din;
    logic [15:0] pdiv;
    logic [1:0]  eState;
    logic [8:0]  eLen;
    logic        eValid;
    logic        eDone;
    logic [11:0] eDuty;
    logic        eFull;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  int nCompared;
  int nMismatched;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] pk(input int x, input int y);
    return {6'(y), 6'(x)};
  endfunction

  function automatic vec_t mk(input logic rec, input logic play,
                              input logic loop, input logic clr,
                              input logic stb, input logic [11:0] din,
                              input logic [15:0] pdiv, input logic [1:0] st,
                              input logic [8:0] len, input logic v,
                              input logic d, input logic [11:0] duty,
                              input logic full);
    vec_t r;
    r.rec = rec; r.play = play; r.loop = loop; r.clr = clr; r.stb = stb;
    r.din = din; r.pdiv = pdiv; r.eState = st; r.eLen = len;
    r.eValid = v; r.eDone = d; r.eDuty = duty; r.eFull = full;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.rec_en     = v.rec;
    bus.play_en    = v.play;
    bus.loop_en    = v.loop;
    bus.clear      = v.clr;
    bus.sample_stb = v.stb;
    bus.duty_in    = v.din;
    bus.play_div   = v.pdiv;
    stepClock();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".state"},     32'(bus.state),     32'd0);
    checkOutput({tag, ".rec_len"},   32'(bus.rec_len),   32'd0);
    checkOutput({tag, ".duty_out"},  32'(bus.duty_out),  32'd0);
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".done"},      32'(bus.done),      32'd0);
    checkOutput({tag, ".full"},      32'(bus.full),      32'd0);
  endtask

  // Main test sequence.
  initial begin
    logic [11:0] s1, s2, s3, s4, s9;
    int n, bad, doneAt, clrCycles;
    logic gotDone;

    nCompared   = 0;
    nMismatched = 0;
    reset          = 1'b1;
    bus.rec_en     = 1'b0;
    bus.play_en    = 1'b0;
    bus.loop_en    = 1'b0;
    bus.clear      = 1'b0;
    bus.sample_stb = 1'b0;
    bus.duty_in    = '0;
    bus.play_div   = '0;

    s1 = pk(1, 2); s2 = pk(3, 4); s3 = pk(5, 6); s4 = pk(7, 8); s9 = pk(9, 9);

    //             rec ply lp clr stb din pdiv | st len v d duty full
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0,  0);
    vecs[1]  = mk(1, 0, 0, 0, 1, s1, 0,  1, 1, 0, 0, 0,  0);
    vecs[2]  = mk(1, 0, 0, 0, 1, s2, 0,  1, 2, 0, 0, 0,  0);
    vecs[3]  = mk(1, 0, 0, 0, 1, s3, 0,  1, 3, 0, 0, 0,  0);
    vecs[4]  = mk(1, 0, 0, 0, 1, s4, 0,  1, 4, 0, 0, 0,  0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0,  0,  0, 4, 0, 0, 0,  0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, 0,  0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, 0,  0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, 0,  0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 1, 0, s1, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s1, 0);
    vecs[12] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 1, 0, s2, 0);
    vecs[13] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s2, 0);
    vecs[14] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s2, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 1, 0, s3, 0);
    vecs[16] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s3, 0);
    vecs[17] = mk(0, 1, 0, 0, 0, 0,  2,  2, 4, 0, 0, s3, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 0,  2,  0, 4, 1, 1, s4, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0,  2,  0, 4, 0, 0, s4, 0);
    vecs[20] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 0, 0, s4, 0);
    vecs[21] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s1, 0);
    vecs[22] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s2, 0);
    vecs[23] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s3, 0);
    vecs[24] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s4, 0);
    vecs[25] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s1, 0);
    vecs[26] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s2, 0);
    vecs[27] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s3, 0);
    vecs[28] = mk(0, 1, 1, 0, 0, 0,  0,  2, 4, 1, 0, s4, 0);
    vecs[29] = mk(0, 0, 1, 0, 0, 0,  0,  0, 4, 0, 0, s4, 0);
    vecs[30] = mk(1, 1, 0, 0, 0, 0,  0,  1, 0, 0, 0, s4, 0);
    vecs[31] = mk(0, 0, 0, 0, 1, s9, 0,  0, 0, 0, 0, s4, 0);
    vecs[32] = mk(0, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0, s4, 0);
    vecs[33] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, s4, 0);

    stepClock();
    stepClock();
    reset = 1'b0;
    checkAllZero("reset");

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec%0d.state", k),     32'(bus.state),     32'(vecs[k].eState));
      checkOutput($sformatf("vec%0d.rec_len", k),   32'(bus.rec_len),   32'(vecs[k].eLen));
      checkOutput($sformatf("vec%0d.out_valid", k), 32'(bus.out_valid), 32'(vecs[k].eValid));
      checkOutput($sformatf("vec%0d.done", k),      32'(bus.done),      32'(vecs[k].eDone));
      checkOutput($sformatf("vec%0d.duty_out", k),  32'(bus.duty_out),  32'(vecs[k].eDuty));
      checkOutput($sformatf("vec%0d.full", k),      32'(bus.full),      32'(vecs[k].eFull));
    end

    // Fill beyond capacity: 260 strobes, only the first 256 are kept.
    bus.rec_en = 1'b1;
    stepClock();
    for (int i = 0; i < 260; i++) begin
      bus.sample_stb = 1'b1;
      bus.duty_in    = 12'(i * 37 + 5);
      stepClock();
      if (i == 254) begin
        checkOutput("fill255.rec_len", 32'(bus.rec_len), 32'd255);
        checkOutput("fill255.full",    32'(bus.full),    32'd0);
      end
    end
    bus.sample_stb = 1'b0;
    checkOutput("full.rec_len", 32'(bus.rec_len), 32'd256);
    checkOutput("full.full",    32'(bus.full),    32'd1);
    checkOutput("full.state",   32'(bus.state),   32'd1);
    bus.rec_en = 1'b0;
    stepClock();
    checkOutput("full.idle", 32'(bus.state), 32'd0);

    // One-shot replay of the full buffer at one sample per cycle.
    bus.play_en  = 1'b1;
    bus.loop_en  = 1'b0;
    bus.play_div = '0;
    stepClock();
    n = 0; bad = 0; doneAt = -1; gotDone = 1'b0;
    for (int c = 0; c < 400 && !gotDone; c++) begin
      stepClock();
      if (bus.out_valid) begin
        if (bus.duty_out !== 12'(n * 37 + 5)) bad++;
        n++;
      end
      if (bus.done) begin
        gotDone = 1'b1;
        doneAt  = n;
      end
    end
    bus.play_en = 1'b0;
    checkOutput("replay.count",     32'(n),      32'd256);
    checkOutput("replay.bad_words", 32'(bad),    32'd0);
    checkOutput("replay.done_at",   32'(doneAt), 32'd256);
    checkOutput("replay.state",     32'(bus.state), 32'd0);

    // Clear wins over record; other inputs are ignored during the sweep.
    bus.clear  = 1'b1;
    bus.rec_en = 1'b1;
    stepClock();
    checkOutput("clear.enter", 32'(bus.state), 32'd3);
    bus.clear      = 1'b0;
    bus.sample_stb = 1'b1;
    bus.play_en    = 1'b1;
    clrCycles = 1;
    for (int c = 0; c < 400; c++) begin
      stepClock();
      if (bus.state != 2'd3) break;
      clrCycles++;
    end
    checkOutput("clear.cycles",   32'(clrCycles),    32'd256);
    checkOutput("clear.state",    32'(bus.state),    32'd0);
    checkOutput("clear.rec_len",  32'(bus.rec_len),  32'd0);
    checkOutput("clear.duty_out", 32'(bus.duty_out), 32'd0);
    bus.rec_en     = 1'b0;
    bus.sample_stb = 1'b0;
    stepClock();
    checkOutput("clear.play_ignored", 32'(bus.state), 32'd0);
    bus.play_en = 1'b0;

    // Reset in the middle of looped playback.
    bus.rec_en = 1'b1;
    stepClock();
    for (int i = 0; i < 4; i++) begin
      bus.sample_stb = 1'b1;
      bus.duty_in    = 12'(12'h111 * (i + 1));
      stepClock();
    end
    bus.sample_stb = 1'b0;
    bus.rec_en     = 1'b0;
    stepClock();
    bus.play_en  = 1'b1;
    bus.loop_en  = 1'b1;
    bus.play_div = '0;
    stepClock();
    stepClock();
    checkOutput("rstplay.valid", 32'(bus.out_valid), 32'd1);
    checkOutput("rstplay.duty",  32'(bus.duty_out),  32'h111);
    reset = 1'b1;
    stepClock();
    checkAllZero("rstplay");
    reset = 1'b0;
    stepClock();
    checkOutput("rstplay.play_ignored", 32'(bus.state), 32'd0);
    bus.play_en = 1'b0;
    bus.loop_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
